// File: rtl/mult_scalar_matrix_seq.sv
// Sequential signed scalar-by-matrix multiplier: one ROWS x COLS row per clock, start/busy/done handshake.
// Build option SATURATE_EN: overflowing elements clamp instead of wrapping.
module mult_scalar_matrix_seq #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ROWS   = 5,
  parameter int unsigned COLS   = 5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [ROWS*COLS*DATA_W-1:0]   m_in,
  input  logic [DATA_W-1:0]             n,
  output logic [ROWS*COLS*DATA_W-1:0]   m_out,
  output logic                          busy,
  output logic                          done,
  output logic                          ovf,
  output logic [ROWS-1:0]               ovf_row
);

  localparam int unsigned ROW_W  = COLS * DATA_W;
  localparam int unsigned MAT_W  = ROWS * ROW_W;
  localparam int unsigned PROD_W = 2 * DATA_W;
  localparam int unsigned CNT_W  = (ROWS > 1) ? $clog2(ROWS) : 1;

  localparam logic [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e                    state_q, state_d;
  logic [CNT_W-1:0]          row_cnt_q, row_cnt_d;
  logic [MAT_W-1:0]          m_lat_q, m_lat_d;
  logic signed [DATA_W-1:0]  n_lat_q, n_lat_d;
  logic [MAT_W-1:0]          m_out_q, m_out_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      ovf_q, ovf_d;
  logic [ROWS-1:0]           ovf_row_q, ovf_row_d;

  logic [ROW_W-1:0]          row_sel_c;
  logic [ROW_W-1:0]          row_res_c;
  logic                      row_ovf_c;

  // Multiply the row addressed by row_cnt_q; overflow when the product's upper bits are not a sign extension.
  always_comb begin : row_datapath
    logic signed [DATA_W-1:0] elem;
    logic signed [PROD_W-1:0] prod;
    logic                     el_ovf;
    row_sel_c = '0;
    row_res_c = '0;
    row_ovf_c = 1'b0;
    elem      = '0;
    prod      = '0;
    el_ovf    = 1'b0;
    for (int r = 0; r < ROWS; r++) begin
      if (row_cnt_q == CNT_W'(r)) begin
        row_sel_c = m_lat_q[(ROWS-r)*ROW_W-1 -: ROW_W];
      end
    end
    for (int c = 0; c < COLS; c++) begin
      elem   = row_sel_c[(COLS-1-c)*DATA_W +: DATA_W];
      prod   = PROD_W'(elem) * PROD_W'(n_lat_q);
      el_ovf = (prod[PROD_W-1:DATA_W-1] != '0) && (prod[PROD_W-1:DATA_W-1] != '1);
`ifdef SATURATE_EN
      row_res_c[(COLS-1-c)*DATA_W +: DATA_W] = el_ovf ? (prod[PROD_W-1] ? SAT_MIN : SAT_MAX)
                                                      : prod[DATA_W-1:0];
`else
      row_res_c[(COLS-1-c)*DATA_W +: DATA_W] = prod[DATA_W-1:0];
`endif
      row_ovf_c = row_ovf_c | el_ovf;
    end
  end

  // Next-state and registered-output logic.
  always_comb begin : fsm_next
    state_d   = state_q;
    row_cnt_d = row_cnt_q;
    m_lat_d   = m_lat_q;
    n_lat_d   = n_lat_q;
    m_out_d   = m_out_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    ovf_d     = ovf_q;
    ovf_row_d = ovf_row_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          m_lat_d   = m_in;
          n_lat_d   = n;
          ovf_d     = 1'b0;
          ovf_row_d = '0;
          row_cnt_d = '0;
          busy_d    = 1'b1;
          state_d   = RUN;
        end
      end
      RUN: begin
        for (int r = 0; r < ROWS; r++) begin
          if (row_cnt_q == CNT_W'(r)) begin
            m_out_d[(ROWS-r)*ROW_W-1 -: ROW_W] = row_res_c;
            ovf_row_d[r]                       = row_ovf_c;
          end
        end
        ovf_d = ovf_q | row_ovf_c;
        if (row_cnt_q == CNT_W'(ROWS-1)) begin
          row_cnt_d = '0;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          state_d   = IDLE;
        end else begin
          row_cnt_d = row_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      row_cnt_q <= '0;
      m_lat_q   <= '0;
      n_lat_q   <= '0;
      m_out_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
      ovf_row_q <= '0;
    end else begin
      state_q   <= state_d;
      row_cnt_q <= row_cnt_d;
      m_lat_q   <= m_lat_d;
      n_lat_q   <= n_lat_d;
      m_out_q   <= m_out_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ovf_q     <= ovf_d;
      ovf_row_q <= ovf_row_d;
    end
  end

  assign m_out   = m_out_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign ovf     = ovf_q;
  assign ovf_row = ovf_row_q;

endmodule

// File: doc/mult_scalar_matrix_seq.md
Name: mult_scalar_matrix_seq

Overview:
- Sequential scalar-by-matrix multiplier for the matrix coprocessor. It is the parametrised successor of the single-row scalar multiplier.
- Multiplies a full ROWS x COLS signed matrix by a signed scalar, one row per clock.
- Uses a start/busy/done handshake and reports overflow per row.
- Sits in the coprocessor datapath behind the instruction decoder, alongside the other matrix ALU units.

Parameters:
- DATA_W, 8: signed element and scalar width in bits.
- ROWS, 5: number of matrix rows.
- COLS, 5: number of elements per row.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  request pulse; sampled only in IDLE.
- m_in  input  ROWS*COLS*DATA_W  signed operand matrix.
- n  input  DATA_W  signed scalar.
- m_out  output  ROWS*COLS*DATA_W  result matrix, registered.
- busy  output  1  high while rows are being computed.
- done  output  1  one-cycle pulse when the result is complete.
- ovf  output  1  sticky OR of all element overflows in the current operation.
- ovf_row  output  ROWS  bit r set if any element of row r overflowed.

Behaviour:
- Packing: first element most significant.
  - Row r occupies m_in[(ROWS-r)*COLS*DATA_W-1 -: COLS*DATA_W].
  - Element c within a row sits at offset (COLS-1-c)*DATA_W.
  - m_out uses the same packing.
- Reset (rst=0, asynchronous): state=IDLE, row counter=0, m_out=0, busy=0, done=0, ovf=0, ovf_row=0, operand registers=0.
- States: IDLE, RUN.
  - IDLE, start=1 at an edge: latch m_in and n, clear ovf/ovf_row, row_cnt=0, busy=1, go to RUN. m_out keeps its previous value until each row is overwritten.
  - RUN, each edge: write row row_cnt of m_out, update ovf_row[row_cnt] and ovf, then increment row_cnt.
  - RUN, edge writing row ROWS-1: busy=0, done=1 for exactly the following cycle, return to IDLE.
- Latency: with start sampled at edge k, row r is written at edge k+1+r. done and final outputs are valid after edge k+ROWS. The default configuration gives 5 cycles.
- start while busy: ignored; the latched operands are unaffected.
- start in the same cycle that done is high: accepted as a new operation. done still drops after one cycle.
- m_in and n may change freely after the start edge.
- Arithmetic:
  - Each product is the full 2*DATA_W-bit signed multiply of the element by n.
  - Overflow occurs when the product is < -2^(DATA_W-1) or > 2^(DATA_W-1)-1.
  - Stored value depends on SATURATE_EN (see below).
  - -128 * -128 at DATA_W=8 is an overflow.
- ovf and ovf_row hold their values until the next accepted start or reset.
- Reset mid-operation aborts immediately with all outputs cleared. The next start runs normally.

Optional Feature:
- Macro: SATURATE_EN.
- Defined: an overflowing element clamps to 2^(DATA_W-1)-1 if the product is positive, or to -2^(DATA_W-1) if negative.
- Undefined: an overflowing element stores the low DATA_W bits of the product (two's-complement wrap).
- ovf and ovf_row behave identically in both builds.

Test Plan:
1. Reset check: hold rst=0 with random inputs and start=1 -> m_out=0, busy=0, done=0, ovf=0, ovf_row=0. Release; outputs stay 0 until start.
2. Positive values: every row [2,3,4,5,0], n=3, start pulse -> busy for 5 cycles, then done pulse. Every row is [6,9,12,15,0] (0x06,0x09,0x0C,0x0F,0x00), ovf=0.
3. Mixed signs: row 0 [2,-3,4,-5,0], other rows 0, n=-3 -> row 0 = [-6,9,-12,15,0] (0xFA,0x09,0xF4,0x0F,0x00), other rows 0, ovf=0.
4. Overflow on last row: row 4 [10,11,12,13,0], n=11.
   - Without SATURATE_EN: row 4 = [110,121,-124,-113,0] (0x6E,0x79,0x84,0x8F,0x00).
   - With SATURATE_EN: row 4 = [110,121,127,127,0].
   - Both builds: ovf=1, ovf_row=5'b10000.
5. Extreme values and start-while-busy: element -128, n=-128 -> stored 0 when wrapping, 127 with SATURATE_EN, ovf=1. A second start with different m_in issued two cycles into RUN is ignored, and the result matches the first operands.
6. Reset mid-run: assert rst=0 during RUN at row_cnt=2 -> all outputs 0 at once. A later start with test 2 operands completes correctly in 5 cycles.
